// File: rtl/hack_mem_arbiter_if.sv
// Bus bundle between the Hack CPU data port, a DMA requester and a single-port data RAM.
interface hack_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 16
);
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_we;
  logic              cpu_re;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ce;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_ack;
  logic [DATA_W-1:0] dma_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, cpu_re,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ce, dma_ack, dma_rdata,
    output mem_addr, mem_wdata, mem_we
  );

  // Requester / RAM side
  modport master (
    output cpu_addr, cpu_wdata, cpu_we, cpu_re,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ce, dma_ack, dma_rdata,
    input  mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/hack_mem_arbiter.sv
// Shares one single-port synchronous RAM between the Hack CPU data port and a DMA port.
// CPU has priority; a starvation counter guarantees the DMA a slot; cpu_ce stalls the CPU.
module hack_mem_arbiter #(
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  hack_mem_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    CPU_RD_WAIT = 2'd1,
    DMA_RD_WAIT = 2'd2,
    DMA_DONE    = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  starve_cnt, starve_nxt;
  logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;
  logic              cpu_lat, dma_lat;
  logic              cpu_acc, dma_eff, cpu_win;

  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic [DATA_W-1:0] cpu_rdata_c;
  logic              mem_we_c, cpu_ce_c, dma_ack_c;

  // Arbitration, RAM steering and CPU stall generation
  always_comb begin
    state_nxt   = state;
    starve_nxt  = starve_cnt;
    mem_addr_c  = bus.cpu_addr;
    mem_wdata_c = bus.cpu_wdata;
    mem_we_c    = 1'b0;
    cpu_ce_c    = 1'b1;
    dma_ack_c   = 1'b0;
    cpu_rdata_c = cpu_rdata_q;
    cpu_lat     = 1'b0;
    dma_lat     = 1'b0;
    cpu_acc     = bus.cpu_re | bus.cpu_we;
    // DMA_DONE arbitrates with the DMA request masked off
    dma_eff     = (state == IDLE) && bus.dma_req;
    cpu_win     = cpu_acc && (!dma_eff || (starve_cnt < LIMIT));

    case (state)
      IDLE, DMA_DONE: begin
        dma_ack_c = (state == DMA_DONE);
        if ((state == IDLE) && !bus.dma_req) starve_nxt = '0;
        if (cpu_win) begin
          if (dma_eff && (starve_cnt < LIMIT)) starve_nxt = starve_cnt + CNT_W'(1);
          if (bus.cpu_re) begin
            cpu_ce_c  = 1'b0;
            state_nxt = CPU_RD_WAIT;
          end else begin
            mem_we_c  = 1'b1;
            state_nxt = IDLE;
          end
        end else if (dma_eff) begin
          starve_nxt  = '0;
          mem_addr_c  = bus.dma_addr;
          mem_wdata_c = bus.dma_wdata;
          mem_we_c    = bus.dma_we;
          cpu_ce_c    = !cpu_acc;
          state_nxt   = bus.dma_we ? DMA_DONE : DMA_RD_WAIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      CPU_RD_WAIT: begin
        // Read data flows through now; a read-modify-write commits its write here
        cpu_rdata_c = bus.mem_rdata;
        cpu_lat     = 1'b1;
        mem_we_c    = bus.cpu_we;
        state_nxt   = IDLE;
      end
      DMA_RD_WAIT: begin
        mem_addr_c = bus.dma_addr;
        dma_lat    = 1'b1;
        cpu_ce_c   = !cpu_acc;
        state_nxt  = DMA_DONE;
      end
      default: state_nxt = IDLE;
    endcase

    if (!RST) begin
      cpu_ce_c  = 1'b0;
      mem_we_c  = 1'b0;
      dma_ack_c = 1'b0;
    end
  end

  // State, starvation counter and read-data holding registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      if (cpu_lat) cpu_rdata_q <= bus.mem_rdata;
      if (dma_lat) dma_rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.cpu_ce    = cpu_ce_c;
  assign bus.cpu_rdata = cpu_rdata_c;
  assign bus.dma_ack   = dma_ack_c;
  assign bus.dma_rdata = dma_rdata_q;

endmodule

// File: doc/hack_mem_arbiter.md
Name: hack_mem_arbiter

Overview:
- Shares one single-port synchronous data RAM between the Hack CPU data port and a second requester (host/debug DMA port).
- Stalls the CPU through a clock-enable output whenever the RAM cannot serve it this cycle.
- Sits between the CPU's addressM/outM/writeM/inM signals and the external RAM.
- Gives the CPU priority, with a starvation limit that guarantees the DMA port a slot.

Parameters:
ADDR_W, 15, address width of CPU, DMA and RAM ports
DATA_W, 16, data word width
STARVE_LIMIT, 4, max consecutive CPU grants while dma_req is pending before DMA wins; 1..15

Ports:
CLK  input  1  system clock, all state on rising edge
RST  input  1  asynchronous, active-low reset
cpu_addr  input  ADDR_W  CPU data address (addressM)
cpu_wdata  input  DATA_W  CPU write data (outM)
cpu_we  input  1  CPU write request (writeM)
cpu_re  input  1  CPU read request (instruction reads M)
cpu_rdata  output  DATA_W  read data to CPU (inM)
cpu_ce  output  1  CPU clock enable; 0 = CPU holds state this cycle
dma_req  input  1  DMA request, held until dma_ack
dma_we  input  1  DMA write (1) / read (0), valid with dma_req
dma_addr  input  ADDR_W  DMA address
dma_wdata  input  DATA_W  DMA write data
dma_ack  output  1  one-cycle completion pulse
dma_rdata  output  DATA_W  DMA read data, valid when dma_ack=1 after a read, held until the next DMA read
mem_addr  output  ADDR_W  RAM address
mem_wdata  output  DATA_W  RAM write data
mem_we  output  1  RAM write strobe
mem_rdata  input  DATA_W  RAM read data, 1-cycle latency after address

Behaviour:
- States: IDLE, CPU_RD_WAIT, DMA_RD_WAIT, DMA_DONE.
- Reset (RST=0, asynchronous):
  - State IDLE; starve_cnt=0; cpu_rdata register=0; dma_rdata=0.
  - While RST=0: cpu_ce=0, mem_we=0, dma_ack=0.
- Grant rule in IDLE, with cpu_acc = cpu_re|cpu_we:
  - CPU wins if cpu_acc and (!dma_req or starve_cnt<STARVE_LIMIT).
  - Otherwise DMA wins if dma_req.
  - With no request: cpu_ce=1, mem_we=0.
- DMA_DONE uses the same grant rule with dma_req masked to 0.
- CPU write grant:
  - mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=1, cpu_ce=1, same cycle.
  - Next state IDLE.
- CPU read grant:
  - mem_addr=cpu_addr, cpu_ce=0, next state CPU_RD_WAIT.
- If cpu_re and cpu_we are both set, the read is served first (CPU_RD_WAIT). The write happens in CPU_RD_WAIT (mem_we=1) together with cpu_ce=1, so the read-modify-write instruction completes in 2 cycles.
- CPU_RD_WAIT:
  - cpu_rdata=mem_rdata combinationally, and the value is latched into the cpu_rdata register.
  - cpu_ce=1; next state IDLE. DMA is not granted in this state.
  - Outside CPU_RD_WAIT, cpu_rdata shows the latched register.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each CPU grant while dma_req=1.
  - Clears on a DMA grant.
  - Clears in IDLE when dma_req=0.
- DMA write grant:
  - mem_addr=dma_addr, mem_wdata=dma_wdata, mem_we=1.
  - cpu_ce=0 if cpu_acc, else 1.
  - Next state DMA_DONE.
- DMA read grant:
  - mem_addr=dma_addr; cpu_ce as for a DMA write; next state DMA_RD_WAIT.
- DMA_RD_WAIT:
  - dma_rdata<=mem_rdata; cpu_ce=0 if cpu_acc, else 1.
  - Next state DMA_DONE.
- DMA_DONE:
  - dma_ack=1; arbitrate the CPU as in IDLE (DMA masked).
  - Next state CPU_RD_WAIT on a CPU read, else IDLE.
- The requester drops dma_req (or presents a new request) in the dma_ack cycle. A request still high afterwards is treated as a new transaction.
- Latency:
  - CPU write 1 cycle, CPU read 2.
  - DMA write ack 1 cycle after grant, DMA read ack 2 cycles after grant.
- mem_we is never asserted in DMA_RD_WAIT.
- Address pass-through is unmodified: no wrap, no decode.
- A reset mid-transaction aborts it with no ack; the requester must reissue.

Test Plan:
- CPU write 0x1234 to 0x0010, no DMA -> same cycle mem_we=1, mem_addr=0x0010, cpu_ce=1; then a CPU read of 0x0010 -> cpu_ce=0,1; cpu_rdata=0x1234 in the second cycle.
- DMA write 0xBEEF @0x0100 with the CPU idle -> mem_we=1 in the grant cycle; dma_ack=1 next cycle only. DMA read @0x0100 -> dma_ack on the 2nd cycle with dma_rdata=0xBEEF.
- CPU issues back-to-back reads with dma_req held, STARVE_LIMIT=4 -> exactly 4 CPU grants, then a DMA grant with cpu_ce=0 that cycle; starve_cnt returns to 0.
- dma_req and CPU write in the same IDLE cycle, starve_cnt=0 -> CPU wins; the DMA is granted in a later cycle. In the DMA_DONE cycle the CPU write is granted with mem_we=1, mem_addr=cpu_addr.
- cpu_re and cpu_we together on address 0x0005 holding 7, outM=8 -> cycle 1 cpu_ce=0; cycle 2 cpu_rdata=7, mem_we=1, mem_wdata=8, cpu_ce=1.
- RST pulled low during DMA_RD_WAIT -> immediately cpu_ce=0, mem_we=0, no dma_ack. After release: state IDLE, cpu_rdata=0, dma_rdata=0; the reissued DMA read completes normally.
